cam_lookup_sched: RTL and testbench

Round-robin scheduler that shares the router's single registered CAM lookup port among NREQ ingress requesters. It accepts at most one key per cycle, drives the CAM's `data_in`, and tracks each in-flight lookup through a tag pipeline. It returns `is_hit`/`addr` to the requester that issued the key. The block sits between the ingress port logic and the `cam` instance; the CAM is instantiated outside and connected through the `cam_*` ports.

---
 rtl/cam_lookup_sched.sv | 133 +++++++++++++
 tb/tb_cam_lookup_sched.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_lookup_sched.sv
// rtl/cam_lookup_sched.sv - round-robin scheduler sharing one registered CAM lookup port
//
// Purpose: accepts at most one key per cycle from NREQ requesters using
// round-robin arbitration. It drives the granted key to the external CAM and
// tracks each lookup through a two-stage tag pipeline. The CAM result is
// returned to the issuing requester two cycles after accept.
//
// Optional feature: define CAM_SCHED_STATS_EN to add saturating 16-bit
// hit/miss counters and the stat_* ports.
//
// Ports:
//   clk, reset        clock; asynchronous active-low reset (shared with the CAM)
//   req_valid/req_key per-requester request and key (requester i at [i*KEY_W +: KEY_W])
//   req_ready         one-hot grant
//   rsp_valid         one-hot single-cycle response strobe
//   rsp_hit/rsp_addr  lookup result, qualified by any rsp_valid bit
//   cam_data_in       key to the CAM (zero when nothing is granted)
//   cam_is_hit/addr   registered CAM result
//   stat_clr/stat_hits/stat_misses  counters (CAM_SCHED_STATS_EN only)
module cam_lookup_sched #(
    parameter int NREQ   = 4,
    parameter int KEY_W  = 4,
    parameter int ADDR_W = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*KEY_W-1:0]   req_key,
    output logic [NREQ-1:0]         req_ready,
    output logic [NREQ-1:0]         rsp_valid,
    output logic                    rsp_hit,
    output logic [ADDR_W-1:0]       rsp_addr,
    output logic [KEY_W-1:0]        cam_data_in,
    input  logic                    cam_is_hit,
    input  logic [ADDR_W-1:0]       cam_addr
`ifdef CAM_SCHED_STATS_EN
    ,
    input  logic                    stat_clr,
    output logic [15:0]             stat_hits,
    output logic [15:0]             stat_misses
`endif
);

    localparam int PW = $clog2(NREQ);

    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] cand;
    logic [PW-1:0] grant_idx;
    logic          grant_found;

    logic          s1_valid;
    logic [PW-1:0] s1_idx;
    logic          s2_valid;
    logic [PW-1:0] s2_idx;

    // Scan from rr_ptr upward; PW-bit addition wraps modulo NREQ because
    // NREQ is a power of two.
    always_comb begin
        cand        = '0;
        grant_idx   = '0;
        grant_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cand = rr_ptr + PW'(k);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        req_ready   = '0;
        cam_data_in = '0;
        if (grant_found) begin
            req_ready   = NREQ'(1) << grant_idx;
            cam_data_in = req_key[int'(grant_idx)*KEY_W +: KEY_W];
        end
    end

    assign rsp_valid = s2_valid ? (NREQ'(1) << s2_idx) : '0;

    // A grant is always a transfer: req_ready is only raised on a valid bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr   <= '0;
            s1_valid <= 1'b0;
            s1_idx   <= '0;
            s2_valid <= 1'b0;
            s2_idx   <= '0;
            rsp_hit  <= 1'b0;
            rsp_addr <= '0;
        end else begin
            if (grant_found) begin
                rr_ptr <= grant_idx + PW'(1);
            end
            s1_valid <= grant_found;
            s1_idx   <= grant_idx;
            s2_valid <= s1_valid;
            s2_idx   <= s1_idx;
            // Result only captured when the CAM output belongs to a real
            // lookup, so idle cycles leave the last response visible.
            if (s1_valid) begin
                rsp_hit  <= cam_is_hit;
                rsp_addr <= cam_addr;
            end
        end
    end

`ifdef CAM_SCHED_STATS_EN
    logic [15:0] stat_hits_q;
    logic [15:0] stat_misses_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_hits_q   <= '0;
            stat_misses_q <= '0;
        end else if (stat_clr) begin
            stat_hits_q   <= '0;
            stat_misses_q <= '0;
        end else if (s2_valid) begin
            if (rsp_hit) begin
                if (stat_hits_q != 16'hFFFF) stat_hits_q <= stat_hits_q + 16'd1;
            end else begin
                if (stat_misses_q != 16'hFFFF) stat_misses_q <= stat_misses_q + 16'd1;
            end
        end
    end

    assign stat_hits   = stat_hits_q;
    assign stat_misses = stat_misses_q;
`endif

endmodule

// File: tb/tb_cam_lookup_sched.sv
// tb/tb_cam_lookup_sched.sv - directed self-checking bench for cam_lookup_sched
module tb_cam_lookup_sched;

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [15:0] req_key;
    logic [3:0]  req_ready;
    logic [3:0]  rsp_valid;
    logic        rsp_hit;
    logic [1:0]  rsp_addr;
    logic [3:0]  cam_data_in;
    logic        cam_is_hit;
    logic [1:0]  cam_addr;
`ifdef CAM_SCHED_STATS_EN
    logic        stat_clr;
    logic [15:0] stat_hits;
    logic [15:0] stat_misses;
`endif

    int n_checks;
    int n_fail;

    cam_lookup_sched #(.NREQ(4), .KEY_W(4), .ADDR_W(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_key    (req_key),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_hit    (rsp_hit),
        .rsp_addr   (rsp_addr),
        .cam_data_in(cam_data_in),
        .cam_is_hit (cam_is_hit),
        .cam_addr   (cam_addr)
`ifdef CAM_SCHED_STATS_EN
        ,
        .stat_clr   (stat_clr),
        .stat_hits  (stat_hits),
        .stat_misses(stat_misses)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered CAM model with table {1011, 1011, 1110, 0001}; lowest
    // matching entry wins, a miss reports address 3.
    function automatic logic [2:0] cam_lookup(input logic [3:0] key);
        logic [3:0] tbl [4];
        tbl[0] = 4'b1011;
        tbl[1] = 4'b1011;
        tbl[2] = 4'b1110;
        tbl[3] = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            if (tbl[i] == key) return {1'b1, 2'(i)};
        end
        return {1'b0, 2'd3};
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            cam_is_hit <= 1'b0;
            cam_addr   <= 2'd0;
        end else begin
            {cam_is_hit, cam_addr} <= cam_lookup(cam_data_in);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b0;
        req_valid = 4'b0000;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        req_valid = 4'b0000;
        req_key   = 16'h0000;
`ifdef CAM_SCHED_STATS_EN
        stat_clr  = 1'b0;
`endif
        @(negedge clk);
        @(negedge clk);
        #1;
        if (rsp_valid !== 4'b0000) begin $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid); n_fail++; end
        n_checks++;
        if (rsp_hit !== 1'b0) begin $display("FAIL reset_rsp_hit: got %b want 0", rsp_hit); n_fail++; end
        n_checks++;
        if (rsp_addr !== 2'd0) begin $display("FAIL reset_rsp_addr: got %0d want 0", rsp_addr); n_fail++; end
        n_checks++;
        if (req_ready !== 4'b0000) begin $display("FAIL reset_req_ready: got %b want 0000", req_ready); n_fail++; end
        n_checks++;
        if (cam_data_in !== 4'b0000) begin $display("FAIL reset_cam_data_in: got %b want 0000", cam_data_in); n_fail++; end
        n_checks++;
`ifdef CAM_SCHED_STATS_EN
        if (stat_hits !== 16'd0 || stat_misses !== 16'd0) begin
            $display("FAIL reset_stats: got %0d/%0d want 0/0", stat_hits, stat_misses); n_fail++;
        end
        n_checks++;
`endif
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_single();
        @(negedge clk);
        req_key   = {4'b0000, 4'b0000, 4'b1110, 4'b0000};
        req_valid = 4'b0010;
        #1;
        if (req_ready !== 4'b0010) begin $display("FAIL single_ready: got %b want 0010", req_ready); n_fail++; end
        n_checks++;
        if (cam_data_in !== 4'b1110) begin $display("FAIL single_cam_data: got %b want 1110", cam_data_in); n_fail++; end
        n_checks++;
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        if (rsp_valid !== 4'b0000) begin $display("FAIL single_early_rsp: got %b want 0000", rsp_valid); n_fail++; end
        n_checks++;
        @(negedge clk);
        #1;
        if (rsp_valid !== 4'b0010) begin $display("FAIL single_rsp_valid: got %b want 0010", rsp_valid); n_fail++; end
        n_checks++;
        if (rsp_hit !== 1'b1) begin $display("FAIL single_rsp_hit: got %b want 1", rsp_hit); n_fail++; end
        n_checks++;
        if (rsp_addr !== 2'd2) begin $display("FAIL single_rsp_addr: got %0d want 2", rsp_addr); n_fail++; end
        n_checks++;
        @(negedge clk);
        #1;
        if (rsp_valid !== 4'b0000) begin $display("FAIL single_pulse_width: got %b want 0000", rsp_valid); n_fail++; end
        n_checks++;
    endtask

    task automatic test_miss();
        // rr_ptr is 2 here; requester 0 is the only one valid so it wins.
        @(negedge clk);
        req_key   = 16'h0000;
        req_valid = 4'b0001;
        #1;
        if (req_ready !== 4'b0001) begin $display("FAIL miss_ready: got %b want 0001", req_ready); n_fail++; end
        n_checks++;
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        #1;
        if (rsp_valid !== 4'b0001 || rsp_hit !== 1'b0 || rsp_addr !== 2'd3) begin
            $display("FAIL miss_rsp: got v=%b hit=%b addr=%0d want v=0001 hit=0 addr=3", rsp_valid, rsp_hit, rsp_addr);
            n_fail++;
        end
        n_checks++;
        @(negedge clk);
        #1;
        if (rsp_valid !== 4'b0000 || rsp_hit !== 1'b0 || rsp_addr !== 2'd3) begin
            $display("FAIL miss_hold: got v=%b hit=%b addr=%0d want v=0000 hit=0 addr=3", rsp_valid, rsp_hit, rsp_addr);
            n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_full_contention();
        logic [3:0] exp_ready;
        logic [3:0] exp_rsp;
        logic       exp_hit [4];
        logic [1:0] exp_addr [4];
        // Keys: r0=1011 (hit 0), r1=1110 (hit 2), r2=0001 (hit 3), r3=0000 (miss 3)
        exp_hit[0] = 1'b1; exp_addr[0] = 2'd0;
        exp_hit[1] = 1'b1; exp_addr[1] = 2'd2;
        exp_hit[2] = 1'b1; exp_addr[2] = 2'd3;
        exp_hit[3] = 1'b0; exp_addr[3] = 2'd3;
        do_reset();
        req_key = {4'b0000, 4'b0001, 4'b1110, 4'b1011};
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            req_valid = (c < 8) ? 4'b1111 : 4'b0000;
            #1;
            exp_ready = (c < 8) ? (4'b0001 << (c % 4)) : 4'b0000;
            if (req_ready !== exp_ready) begin
                $display("FAIL full_ready[%0d]: got %b want %b", c, req_ready, exp_ready); n_fail++;
            end
            n_checks++;
            exp_rsp = (c >= 2) ? (4'b0001 << ((c - 2) % 4)) : 4'b0000;
            if (rsp_valid !== exp_rsp) begin
                $display("FAIL full_rsp_valid[%0d]: got %b want %b", c, rsp_valid, exp_rsp); n_fail++;
            end
            n_checks++;
            if (c >= 2) begin
                if (rsp_hit !== exp_hit[(c - 2) % 4] || rsp_addr !== exp_addr[(c - 2) % 4]) begin
                    $display("FAIL full_rsp_data[%0d]: got hit=%b addr=%0d want hit=%b addr=%0d",
                             c, rsp_hit, rsp_addr, exp_hit[(c - 2) % 4], exp_addr[(c - 2) % 4]);
                    n_fail++;
                end
                n_checks++;
            end
        end
    endtask

    task automatic test_rotation();
        // rr_ptr is 0 after full contention ended on requester 3.
        @(negedge clk);
        req_valid = 4'b0100;
        #1;
        if (req_ready !== 4'b0100) begin $display("FAIL rot_grant2: got %b want 0100", req_ready); n_fail++; end
        n_checks++;
        @(negedge clk);
        req_valid = 4'b1001;
        #1;
        if (req_ready !== 4'b1000) begin $display("FAIL rot_grant3: got %b want 1000", req_ready); n_fail++; end
        n_checks++;
        @(negedge clk);
        #1;
        if (req_ready !== 4'b0001) begin $display("FAIL rot_grant0: got %b want 0001", req_ready); n_fail++; end
        n_checks++;
        if (rsp_valid !== 4'b0100) begin $display("FAIL rot_rsp2: got %b want 0100", rsp_valid); n_fail++; end
        n_checks++;
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        if (rsp_valid !== 4'b1000) begin $display("FAIL rot_rsp3: got %b want 1000", rsp_valid); n_fail++; end
        n_checks++;
        @(negedge clk);
        #1;
        if (rsp_valid !== 4'b0001) begin $display("FAIL rot_rsp0: got %b want 0001", rsp_valid); n_fail++; end
        n_checks++;
    endtask

    task automatic test_back_to_back();
        // A lone requester is granted every cycle; its grants and responses overlap.
        req_key = {4'b0000, 4'b0000, 4'b1110, 4'b0000};
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            req_valid = (c < 3) ? 4'b0010 : 4'b0000;
            #1;
            if (req_ready !== ((c < 3) ? 4'b0010 : 4'b0000)) begin
                $display("FAIL b2b_ready[%0d]: got %b", c, req_ready); n_fail++;
            end
            n_checks++;
            if (c >= 2) begin
                if (rsp_valid !== 4'b0010 || rsp_hit !== 1'b1 || rsp_addr !== 2'd2) begin
                    $display("FAIL b2b_rsp[%0d]: got v=%b hit=%b addr=%0d want v=0010 hit=1 addr=2",
                             c, rsp_valid, rsp_hit, rsp_addr);
                    n_fail++;
                end
                n_checks++;
            end
        end
        @(negedge clk);
        #1;
        if (rsp_valid !== 4'b0000) begin $display("FAIL b2b_tail: got %b want 0000", rsp_valid); n_fail++; end
        n_checks++;
    endtask

    task automatic test_reset_midflight();
        // rr_ptr is 2; accepting requester 0 moves it to 1 before the reset.
        @(negedge clk);
        req_key   = {4'b0000, 4'b0000, 4'b0000, 4'b1011};
        req_valid = 4'b0001;
        #1;
        if (req_ready !== 4'b0001) begin $display("FAIL rst_mid_accept: got %b want 0001", req_ready); n_fail++; end
        n_checks++;
        @(negedge clk);
        req_valid = 4'b0000;
        reset     = 1'b0;
        #1;
        if (rsp_valid !== 4'b0000) begin $display("FAIL rst_mid_during: got %b want 0000", rsp_valid); n_fail++; end
        n_checks++;
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            if (rsp_valid !== 4'b0000) begin
                $display("FAIL rst_mid_flush[%0d]: got %b want 0000", c, rsp_valid); n_fail++;
            end
            n_checks++;
        end
        req_valid = 4'b1111;
        #1;
        if (req_ready !== 4'b0001) begin $display("FAIL rst_mid_ptr: got %b want 0001", req_ready); n_fail++; end
        n_checks++;
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        @(negedge clk);
    endtask

`ifdef CAM_SCHED_STATS_EN
    task automatic send_r0(input logic [3:0] key);
        @(negedge clk);
        req_key   = {12'h000, key};
        req_valid = 4'b0001;
        @(negedge clk);
        req_valid = 4'b0000;
    endtask

    task automatic test_stats();
        do_reset();
        send_r0(4'b1011);
        send_r0(4'b1110);
        send_r0(4'b0000);
        send_r0(4'b0001);
        send_r0(4'b0000);
        repeat (4) @(negedge clk);
        #1;
        if (stat_hits !== 16'd3 || stat_misses !== 16'd2) begin
            $display("FAIL stats_count: got %0d/%0d want 3/2", stat_hits, stat_misses); n_fail++;
        end
        n_checks++;
        force dut.stat_hits_q = 16'hFFFF;
        @(negedge clk);
        release dut.stat_hits_q;
        send_r0(4'b1110);
        repeat (3) @(negedge clk);
        #1;
        if (stat_hits !== 16'hFFFF) begin
            $display("FAIL stats_saturate: got %h want ffff", stat_hits); n_fail++;
        end
        n_checks++;
        // Hit accepted in T; its response is in T+2, where stat_clr is raised.
        @(negedge clk);
        req_key   = {12'h000, 4'b1110};
        req_valid = 4'b0001;
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        #1;
        if (stat_hits !== 16'd0 || stat_misses !== 16'd0) begin
            $display("FAIL stats_clr_priority: got %0d/%0d want 0/0", stat_hits, stat_misses); n_fail++;
        end
        n_checks++;
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_single();
        test_miss();
        test_full_contention();
        test_rotation();
        test_back_to_back();
        test_reset_midflight();
`ifdef CAM_SCHED_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
